mem_line_engine: RTL

//   Initiator side of the simulation memory port: turns one cache-line request
//   (fill or write-back) from the cache into LINE_WORDS single-word memory beats.

---
 rtl/mem_line_engine.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mem_line_engine.sv
// Cache-line engine on the initiator side of the memory port: splits one fill or
// write-back line into LINE_WORDS single-word beats and returns the assembled line.
`ifndef MEM_ADDR_SIZE
`define MEM_ADDR_SIZE 16
`endif
`ifndef MEM_BANDWIDTH
`define MEM_BANDWIDTH 8
`endif

module mem_line_engine #(
  parameter int ADDR_W     = `MEM_ADDR_SIZE,
  parameter int DATA_W     = `MEM_BANDWIDTH * 8,
  parameter int LINE_WORDS = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [LINE_WORDS*DATA_W-1:0] req_wdata,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [LINE_WORDS*DATA_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_write_data,
  output logic                         mem_write_valid,
  output logic                         mem_read_valid,
  input  logic [DATA_W-1:0]            mem_data,
  input  logic                         mem_valid
);

  localparam int BW   = $clog2(LINE_WORDS);
  localparam int LW   = LINE_WORDS * DATA_W;
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [ADDR_W-1:0] LINE_MASK = ~ADDR_W'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, RESP = 2'd3} state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       beat_q, beat_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [LW-1:0]       buf_q, buf_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [LW-1:0]       resp_rdata_q, resp_rdata_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_write_data_q, mem_write_data_d;
  logic                mem_write_valid_q, mem_write_valid_d;
  logic                mem_read_valid_q, mem_read_valid_d;
  logic [DATA_W-1:0]   wr_word_s;

  // Next-state, beat counter and line buffer update.
  always_comb begin
    state_d = state_q;
    beat_d  = beat_q;
    base_d  = base_q;
    buf_d   = buf_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          base_d  = req_addr & LINE_MASK;
          buf_d   = req_wdata;
          beat_d  = {BW{1'b0}};
          state_d = req_write ? WRITE : READ;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE: begin
        if (beat_q == LAST_BEAT) begin
          state_d = RESP;
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      READ: begin
        if (mem_valid) begin
          for (int w = 0; w < LINE_WORDS; w++) begin
            buf_d[w*DATA_W +: DATA_W] = (beat_q == BW'(w)) ? mem_data : buf_q[w*DATA_W +: DATA_W];
          end
          if (beat_q == LAST_BEAT) begin
            state_d = RESP;
          end else begin
            beat_d = beat_q + BW'(1);
          end
        end else begin
          state_d = READ;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d = IDLE;
          beat_d  = {BW{1'b0}};
        end else begin
          state_d = RESP;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = {BW{1'b0}};
      end
    endcase
  end

  // Outputs are registered copies decoded from the upcoming state, so each one
  // lines up with the state it describes without any input-to-output path.
  always_comb begin
    wr_word_s = {DATA_W{1'b0}};
    for (int w = 0; w < LINE_WORDS; w++) begin
      wr_word_s = (beat_d == BW'(w)) ? buf_d[w*DATA_W +: DATA_W] : wr_word_s;
    end
    req_ready_d       = (state_d == IDLE);
    resp_valid_d      = (state_d == RESP);
    resp_rdata_d      = (state_d == RESP) ? buf_d : {LW{1'b0}};
    mem_write_valid_d = (state_d == WRITE);
    mem_read_valid_d  = (state_d == READ);
    mem_addr_d        = ((state_d == WRITE) || (state_d == READ)) ?
                        (base_d | ADDR_W'(beat_d)) : {ADDR_W{1'b0}};
    mem_write_data_d  = (state_d == WRITE) ? wr_word_s : {DATA_W{1'b0}};
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q           <= IDLE;
      beat_q            <= {BW{1'b0}};
      base_q            <= {ADDR_W{1'b0}};
      buf_q             <= {LW{1'b0}};
      req_ready_q       <= 1'b1;
      resp_valid_q      <= 1'b0;
      resp_rdata_q      <= {LW{1'b0}};
      mem_addr_q        <= {ADDR_W{1'b0}};
      mem_write_data_q  <= {DATA_W{1'b0}};
      mem_write_valid_q <= 1'b0;
      mem_read_valid_q  <= 1'b0;
    end else begin
      state_q           <= state_d;
      beat_q            <= beat_d;
      base_q            <= base_d;
      buf_q             <= buf_d;
      req_ready_q       <= req_ready_d;
      resp_valid_q      <= resp_valid_d;
      resp_rdata_q      <= resp_rdata_d;
      mem_addr_q        <= mem_addr_d;
      mem_write_data_q  <= mem_write_data_d;
      mem_write_valid_q <= mem_write_valid_d;
      mem_read_valid_q  <= mem_read_valid_d;
    end
  end

  assign req_ready       = req_ready_q;
  assign resp_valid      = resp_valid_q;
  assign resp_rdata      = resp_rdata_q;
  assign mem_addr        = mem_addr_q;
  assign mem_write_data  = mem_write_data_q;
  assign mem_write_valid = mem_write_valid_q;
  assign mem_read_valid  = mem_read_valid_q;

endmodule
